// File: rtl/sram_arbiter.sv
// Three-way arbiter (fetch, data, controller) for the shared 2048x32 SRAM, including routing of 1-cycle read returns.
// Optional grant/stall counters are included when SRAM_ARB_PERF_EN is defined.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic                  c_lock,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
`ifdef SRAM_ARB_PERF_EN
  input  logic                  perf_clr,
  output logic [15:0]           perf_f_cnt,
  output logic [15:0]           perf_d_cnt,
  output logic [15:0]           perf_c_cnt,
  output logic [15:0]           perf_stall_cnt,
`endif
  output logic                  lock_active
);

  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

  localparam logic [1:0] TAG_F = 2'd0;
  localparam logic [1:0] TAG_D = 2'd1;
  localparam logic [1:0] TAG_C = 2'd2;

  state_t     state_q, state_d;
  logic       rr_q, rr_d;
  logic       rd_pend_q, rd_pend_d;
  logic [1:0] rd_tag_q, rd_tag_d;

  logic d_rd, d_wr, c_rd, c_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ARB;
      rr_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_tag_q  <= TAG_F;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      rd_pend_q <= rd_pend_d;
      rd_tag_q  <= rd_tag_d;
    end
  end

  // Grant selection; everything is held off while reset is asserted.
  always_comb begin
    f_gnt   = 1'b0;
    d_gnt   = 1'b0;
    c_gnt   = 1'b0;
    state_d = state_q;
    if (!rst) begin
      unique case (state_q)
        ST_ARB: begin
          if (c_req) begin
            c_gnt = 1'b1;
          end else if (!rr_q) begin
            if (f_req)      f_gnt = 1'b1;
            else if (d_req) d_gnt = 1'b1;
          end else begin
            if (d_req)      d_gnt = 1'b1;
            else if (f_req) f_gnt = 1'b1;
          end
          if (c_gnt && c_lock) state_d = ST_LOCK;
        end
        ST_LOCK: begin
          c_gnt = c_req;
          if (!c_lock) state_d = ST_ARB;
        end
        default: state_d = ST_ARB;
      endcase
    end
  end

  assign d_rd = d_gnt & ~d_we;
  assign d_wr = d_gnt &  d_we;
  assign c_rd = c_gnt & ~c_we;
  assign c_wr = c_gnt &  c_we;

  always_comb begin
    mem_rd      = f_gnt | d_rd | c_rd;
    mem_wr      = d_wr | c_wr;
    mem_rd_addr = '0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (f_gnt)     mem_rd_addr = f_addr;
    else if (d_rd) mem_rd_addr = d_addr;
    else if (c_rd) mem_rd_addr = c_addr;
    if (d_wr) begin
      mem_wr_addr = d_addr;
      mem_wr_data = d_wdata;
    end else if (c_wr) begin
      mem_wr_addr = c_addr;
      mem_wr_data = c_wdata;
    end
  end

  // Round-robin pointer favours whichever of F/D lost the last F/D grant.
  always_comb begin
    rr_d      = rr_q;
    rd_pend_d = mem_rd;
    rd_tag_d  = rd_tag_q;
    if (f_gnt)      rr_d = 1'b1;
    else if (d_gnt) rr_d = 1'b0;
    if (f_gnt)     rd_tag_d = TAG_F;
    else if (d_rd) rd_tag_d = TAG_D;
    else if (c_rd) rd_tag_d = TAG_C;
  end

  // Gating with rst drops a read that was in flight when reset arrived.
  always_comb begin
    f_rvalid = rd_pend_q & ~rst & (rd_tag_q == TAG_F);
    d_rvalid = rd_pend_q & ~rst & (rd_tag_q == TAG_D);
    c_rvalid = rd_pend_q & ~rst & (rd_tag_q == TAG_C);
    f_rdata  = f_rvalid ? mem_rd_data : '0;
    d_rdata  = d_rvalid ? mem_rd_data : '0;
    c_rdata  = c_rvalid ? mem_rd_data : '0;
  end

  assign lock_active = (state_q == ST_LOCK) & ~rst;

`ifdef SRAM_ARB_PERF_EN
  logic [15:0] perf_q [4];
  logic [15:0] perf_d [4];
  logic [3:0]  perf_inc;

  assign perf_inc[0] = f_gnt;
  assign perf_inc[1] = d_gnt;
  assign perf_inc[2] = c_gnt;
  assign perf_inc[3] = (f_req & ~f_gnt) | (d_req & ~d_gnt) | (c_req & ~c_gnt);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_perf
      always_comb begin
        perf_d[gi] = perf_q[gi];
        if (perf_clr)                                 perf_d[gi] = '0;
        else if (perf_inc[gi] && perf_q[gi] != 16'hFFFF) perf_d[gi] = perf_q[gi] + 16'd1;
      end
      always_ff @(posedge clk) begin
        if (rst) perf_q[gi] <= '0;
        else     perf_q[gi] <= perf_d[gi];
      end
    end
  endgenerate

  assign perf_f_cnt     = perf_q[0];
  assign perf_d_cnt     = perf_q[1];
  assign perf_c_cnt     = perf_q[2];
  assign perf_stall_cnt = perf_q[3];
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 2048x32 SRAM holding 32'hDEAD_0000 + address at start.
module tb_sram_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, f_gnt, f_rvalid;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          c_req, c_we, c_lock, c_gnt, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          mem_rd, mem_wr, lock_active;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [DW-1:0] mem_rd_data, mem_wr_data;
`ifdef SRAM_ARB_PERF_EN
  logic          perf_clr;
  logic [15:0]   perf_f_cnt, perf_d_cnt, perf_c_cnt, perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .mem_rd(mem_rd), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
`ifdef SRAM_ARB_PERF_EN
    .perf_clr(perf_clr), .perf_f_cnt(perf_f_cnt), .perf_d_cnt(perf_d_cnt),
    .perf_c_cnt(perf_c_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .lock_active(lock_active)
  );

  logic [DW-1:0] mem [2048];
  initial begin
    mem_rd_data = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'hDEAD_0000 + i;
  end
  always @(posedge clk) begin
    if (mem_wr) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("check %s ok (%h)", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    f_req = 0; f_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    c_req = 0; c_we = 0; c_lock = 0; c_addr = '0; c_wdata = '0;
  endtask

  initial begin
    logic [31:0] wdat;
    idle();
`ifdef SRAM_ARB_PERF_EN
    perf_clr = 0;
`endif
    rst = 1; f_req = 1;
    #3;
    check("rst_f_gnt", f_gnt, 0);
    check("rst_mem_rd", mem_rd, 0);
    tick(); settle();
    check("rst_lock", lock_active, 0);
    check("rst_f_rvalid", f_rvalid, 0);
    check("rst_f_rdata", f_rdata, 0);

    // Controller writes then reads back address 6
    for (int k = 0; k < 3; k++) begin
      tick();
      rst = 0; f_req = 0;
      c_req = 1; c_we = 1; c_addr = 11'(5 + k); wdat = 32'hA5A5_0001 + k; c_wdata = wdat;
      settle();
      check("cw_gnt", c_gnt, 1);
      check("cw_mem_wr", mem_wr, 1);
      check("cw_addr", 32'(mem_wr_addr), 32'(5 + k));
      check("cw_data", mem_wr_data, wdat);
    end
    tick(); c_we = 0; c_addr = 11'd6; c_wdata = '0; settle();
    check("cr_gnt", c_gnt, 1);
    check("cr_mem_rd", mem_rd, 1);
    tick(); idle(); settle();
    check("cr_rvalid", c_rvalid, 1);
    check("cr_rdata", c_rdata, 32'hA5A5_0002);
    check("cr_f_rvalid", f_rvalid, 0);
    check("cr_d_rvalid", d_rvalid, 0);

    // Fresh reset, then F and D both requesting continuously
    tick(); rst = 1; settle();
    tick(); rst = 0; f_req = 1; f_addr = 11'd20; d_req = 1; d_addr = 11'd30;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      settle();
      check("alt_f_gnt", f_gnt, (k % 2) == 0);
      check("alt_d_gnt", d_gnt, (k % 2) == 1);
      if (k > 0) begin
        check("alt_f_rvalid", f_rvalid, ((k - 1) % 2) == 0);
        check("alt_d_rvalid", d_rvalid, ((k - 1) % 2) == 1);
        check("alt_f_rdata", f_rdata, ((k - 1) % 2) == 0 ? 32'hDEAD_0014 : 32'h0);
        check("alt_d_rdata", d_rdata, ((k - 1) % 2) == 1 ? 32'hDEAD_001E : 32'h0);
      end
    end
    tick(); idle(); settle();
    check("alt_last_d_rvalid", d_rvalid, 1);
    check("alt_last_d_rdata", d_rdata, 32'hDEAD_001E);
    check("alt_last_f_rvalid", f_rvalid, 0);

    // Three-way contention: C, then F (rr=0), then D
    tick();
    c_req = 1; c_addr = 11'd6; f_req = 1; f_addr = 11'd20; d_req = 1; d_addr = 11'd30;
    settle();
    check("pri_c_gnt", c_gnt, 1);
    check("pri_f_stall", f_gnt, 0);
    check("pri_d_stall", d_gnt, 0);
    tick(); c_req = 0; settle();
    check("pri_f_gnt", f_gnt, 1);
    check("pri_d_wait", d_gnt, 0);
    check("pri_c_rdata", c_rdata, 32'hA5A5_0002);
    tick(); f_req = 0; settle();
    check("pri_d_gnt", d_gnt, 1);
    check("pri_f_rdata", f_rdata, 32'hDEAD_0014);
    tick(); idle(); settle();
    check("pri_d_rdata", d_rdata, 32'hDEAD_001E);

    // Controller lock while fetch waits
    for (int k = 0; k < 4; k++) begin
      tick();
      c_req = 1; c_lock = 1; c_addr = 11'd7; f_req = 1; f_addr = 11'd20;
      settle();
      check("lk_c_gnt", c_gnt, 1);
      check("lk_f_gnt", f_gnt, 0);
      check("lk_active", lock_active, k > 0);
      if (k > 0) check("lk_c_rdata", c_rdata, 32'hA5A5_0003);
    end
    tick(); c_req = 0; c_lock = 0; settle();
    check("lk_last_c_rdata", c_rdata, 32'hA5A5_0003);
    tick(); settle();
    check("unlk_f_gnt", f_gnt, 1);
    check("unlk_active", lock_active, 0);
    tick(); idle(); settle();
    check("unlk_f_rdata", f_rdata, 32'hDEAD_0014);

    // D write then F read of the same address
    tick(); d_req = 1; d_we = 1; d_addr = 11'd9; d_wdata = 32'h1234_5678; settle();
    check("wr_d_gnt", d_gnt, 1);
    check("wr_mem_wr", mem_wr, 1);
    check("wr_mem_rd", mem_rd, 0);
    check("wr_data", mem_wr_data, 32'h1234_5678);
    tick(); idle(); f_req = 1; f_addr = 11'd9; settle();
    check("rd9_f_gnt", f_gnt, 1);
    check("rd9_addr", 32'(mem_rd_addr), 32'd9);
    tick(); idle(); settle();
    check("rd9_f_rvalid", f_rvalid, 1);
    check("rd9_f_rdata", f_rdata, 32'h1234_5678);

    // Reset while a D read is in flight
    tick(); d_req = 1; d_addr = 11'd30; settle();
    check("rr_d_gnt", d_gnt, 1);
    tick(); idle(); rst = 1; f_req = 1; f_addr = 11'd20; settle();
    check("rr_d_rvalid", d_rvalid, 0);
    check("rr_d_rdata", d_rdata, 0);
    check("rr_f_gnt", f_gnt, 0);
    check("rr_mem_rd", mem_rd, 0);
    check("rr_lock", lock_active, 0);
    tick(); rst = 0; d_req = 1; d_addr = 11'd30; settle();
    check("post_f_gnt", f_gnt, 1);
    check("post_d_gnt", d_gnt, 0);
    check("post_d_rvalid", d_rvalid, 0);
    tick(); f_req = 0; settle();
    check("post2_d_gnt", d_gnt, 1);
    check("post2_f_rdata", f_rdata, 32'hDEAD_0014);
    tick(); idle(); settle();
    check("post3_d_rdata", d_rdata, 32'hDEAD_001E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 2048x32 instruction/data SRAM between three requesters: instruction fetch (read-only), core load/store data port, and the external controller/loader port.
- Issues at most one SRAM access per cycle and tracks the 1-cycle SRAM read latency so read data returns to the requester that issued the read.
- Sits between the fetch unit, LSU and controller on one side and sram_8kb on the other. Replaces their direct SRAM hookup.

Parameters:
- ADDR_WIDTH, 11, word address width (2048 words).
- DATA_WIDTH, 32, data word width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- f_req  in  1  fetch read request; held until granted.
- f_addr  in  ADDR_WIDTH  fetch word address.
- f_gnt  out  1  fetch granted this cycle (combinational).
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  DATA_WIDTH  fetch read data.
- d_req, d_we  in  1 each  data request; write when d_we=1.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  data write data.
- d_gnt, d_rvalid  out  1 each  data grant; data read valid.
- d_rdata  out  DATA_WIDTH  data read data.
- c_req, c_we  in  1 each  controller request and write select.
- c_lock  in  1  controller exclusive-lock request.
- c_addr  in  ADDR_WIDTH  controller address.
- c_wdata  in  DATA_WIDTH  controller write data.
- c_gnt, c_rvalid  out  1 each  controller grant; controller read valid.
- c_rdata  out  DATA_WIDTH  controller read data.
- mem_rd  out  1  SRAM read enable.
- mem_rd_addr  out  ADDR_WIDTH  SRAM read address.
- mem_rd_data  in  DATA_WIDTH  SRAM registered read data, valid the cycle after mem_rd.
- mem_wr  out  1  SRAM write enable.
- mem_wr_addr  out  ADDR_WIDTH  SRAM write address.
- mem_wr_data  out  DATA_WIDTH  SRAM write data.
- lock_active  out  1  arbiter is in LOCK state.

Behaviour:
- Handshake
  - Each requester holds req/addr/we/wdata stable until gnt.
  - The transfer happens in the cycle where req&gnt. At most one gnt is high per cycle.
  - mem_* outputs are driven combinationally from the granted requester.
  - mem_rd=gnt&~we; mem_wr=gnt&we (fetch is always a read).
  - Non-granted mem address/data outputs are 0.
- Read return
  - A read granted in cycle N asserts the matching *_rvalid for exactly one cycle in N+1.
  - *_rdata = mem_rd_data in that cycle; otherwise *_rdata=0.
  - Tracked by registers rd_pend (1 bit) and rd_tag (2 bits: 0=F, 1=D, 2=C).
  - Back-to-back reads in consecutive cycles are allowed (full throughput).
- States
  - ARB -> LOCK when c_req&c_lock is granted.
  - LOCK -> ARB on the first cycle c_lock=0, evaluated at posedge. Arbitration in that cycle is ARB-rules.
- ARB priority
  - Controller highest (fixed).
  - Then fetch vs data by round-robin pointer rr (0: fetch first, 1: data first).
  - rr updates only on an F or D grant: it points to the non-granted one of the pair.
  - rr is unchanged on a C grant or an idle cycle.
- LOCK
  - Only the controller is granted; f_gnt=d_gnt=0.
  - A read issued before entering LOCK still returns its rvalid to its owner.
- Write then read, same address: serialized by the grant rule. A read granted in any cycle after the write cycle returns the new data.
- Reset
  - Values: state=ARB, rr=0, rd_pend=0, rd_tag=0, lock_active=0, all *_rvalid=0, all *_rdata=0.
  - gnt/mem_* are forced 0 while rst=1.
  - Reset mid-operation: an in-flight read returns no rvalid.
- Conflict guarantee: with F and D both continuously requesting, they alternate grants.

Optional Feature:
- Macro SRAM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_f_cnt, perf_d_cnt, perf_c_cnt (16 bits each): grant counts.
  - Adds output perf_stall_cnt (16 bits): cycles where any req was high and not granted.
  - All four counters saturate at 16'hFFFF and clear on rst.
  - Adds input perf_clr (1 bit): synchronous clear, which takes priority over increment.
- Undefined: these ports and registers are absent. Behaviour is otherwise identical.

Test Plan:
- Controller writes 32'hA5A5_0001/2/3 to addresses 5/6/7, then c_req reads address 6 -> c_gnt the same cycle, c_rvalid the next cycle with c_rdata=32'hA5A5_0002, f_rvalid=d_rvalid=0.
- f_req and d_req held high for 6 cycles from reset -> grants F,D,F,D,F,D; each rvalid is routed one cycle later to the correct requester.
- c_req, f_req and d_req all high -> C granted first, then F (rr=0), then D; F and D stall with gnt=0 while waiting.
- c_lock=1 with c_req for 4 cycles while f_req is high -> lock_active=1, f_gnt=0 throughout; after c_lock drops, f_gnt=1 on the next cycle.
- D write to address 9 with data 32'h1234_5678, then F read of address 9 -> f_rdata=32'h1234_5678.
- D read granted, then rst=1 in the next cycle -> d_rvalid=0 and all outputs at reset values; normal grants resume after rst=0.
